// File: rtl/mips_cpu_pc_seq.sv
// Program-counter sequencer for the multicycle MIPS core.
// Handles sequential fetch, relative branches, absolute J-format jumps and
// register jumps. It can model the architectural branch delay slot or redirect
// immediately. It also detects halt (a jump to HALT_ADDR) and misaligned targets.
module mips_cpu_pc_seq #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
   parameter logic [31:0] HALT_ADDR    = 32'h00000000,
   parameter bit          DELAY_SLOT   = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        update_pc,
   input  logic [1:0]  redirect_kind,
   input  logic [15:0] branch_imm,
   input  logic [25:0] jump_index,
   input  logic [31:0] jump_reg,
   output logic [31:0] pc,
   output logic [31:0] pc_link,
   output logic        in_delay_slot,
   output logic        halted,
   output logic        addr_error
);

   typedef enum logic [1:0] {
      RUN,
      SLOT,
      HALTED
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] pc_next;
   logic        delay_slot_next;
   logic        halted_next;
   logic        addr_error_next;
   logic [31:0] target_q;
   logic [31:0] target_q_next;
   logic        bad_q;
   logic        bad_q_next;
   logic [31:0] pc_plus4;
   logic [31:0] branch_offset;
   logic [31:0] target;
   logic        target_bad;
   logic        commit;
   logic [31:0] commit_target;
   logic        commit_bad;

   // Link value for JAL/JALR: the instruction after the delay slot.
   assign pc_link = pc + 32'd8;

   // Redirect target computed from the current pc and the selected kind.
   always_comb begin
      pc_plus4      = pc + 32'd4;
      branch_offset = {{14{branch_imm[15]}}, branch_imm, 2'b00};
      target        = pc_plus4;
      case (redirect_kind)
         2'b01:   target = pc_plus4 + branch_offset;
         2'b10:   target = {pc_plus4[31:28], jump_index, 2'b00};
         2'b11:   target = jump_reg;
         default: target = pc_plus4;
      endcase
      target_bad = (target[1:0] != 2'b00);
   end

   // Next-state logic: advance, enter or drain the delay slot, then commit.
   always_comb begin
      state_next      = state;
      pc_next         = pc;
      delay_slot_next = in_delay_slot;
      halted_next     = halted;
      addr_error_next = addr_error;
      target_q_next   = target_q;
      bad_q_next      = bad_q;
      commit          = 1'b0;
      commit_target   = target_q;
      commit_bad      = bad_q;

      case (state)
         RUN: begin
            if (update_pc) begin
               if (redirect_kind == 2'b00) begin
                  pc_next = pc_plus4;
               end else begin
                  target_q_next = target;
                  bad_q_next    = target_bad;
                  if (DELAY_SLOT) begin
                     pc_next         = pc_plus4;
                     delay_slot_next = 1'b1;
                     state_next      = SLOT;
                  end else begin
                     commit        = 1'b1;
                     commit_target = target;
                     commit_bad    = target_bad;
                  end
               end
            end
         end
         SLOT: begin
            // A redirect requested from inside the delay slot is dropped.
            if (update_pc) begin
               commit          = 1'b1;
               delay_slot_next = 1'b0;
            end
         end
         default: begin
         end
      endcase

      if (commit) begin
         if (commit_bad) begin
            addr_error_next = 1'b1;
            halted_next     = 1'b1;
            state_next      = HALTED;
         end else if (commit_target == HALT_ADDR) begin
            pc_next     = HALT_ADDR;
            halted_next = 1'b1;
            state_next  = HALTED;
         end else begin
            pc_next    = commit_target;
            state_next = RUN;
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= RUN;
         pc            <= RESET_VECTOR;
         in_delay_slot <= 1'b0;
         halted        <= 1'b0;
         addr_error    <= 1'b0;
         target_q      <= 32'd0;
         bad_q         <= 1'b0;
      end else begin
         state         <= state_next;
         pc            <= pc_next;
         in_delay_slot <= delay_slot_next;
         halted        <= halted_next;
         addr_error    <= addr_error_next;
         target_q      <= target_q_next;
         bad_q         <= bad_q_next;
      end
   end

endmodule

// File: tb/tb_mips_cpu_pc_seq.sv
// Directed testbench for mips_cpu_pc_seq with both delay-slot variants.
module tb_mips_cpu_pc_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        update_pc = 1'b0;
   logic        update_pc0 = 1'b0;
   logic [1:0]  redirect_kind = 2'b00;
   logic [15:0] branch_imm = 16'h0;
   logic [25:0] jump_index = 26'h0;
   logic [31:0] jump_reg = 32'h0;

   logic [31:0] pc, pc_link, pc0, pc_link0;
   logic        in_delay_slot, halted, addr_error;
   logic        in_delay_slot0, halted0, addr_error0;

   int checks = 0;
   int errors = 0;

   mips_cpu_pc_seq #(.DELAY_SLOT(1'b1)) dut (
      .clk(clk), .reset(reset), .update_pc(update_pc),
      .redirect_kind(redirect_kind), .branch_imm(branch_imm),
      .jump_index(jump_index), .jump_reg(jump_reg),
      .pc(pc), .pc_link(pc_link), .in_delay_slot(in_delay_slot),
      .halted(halted), .addr_error(addr_error)
   );

   mips_cpu_pc_seq #(.DELAY_SLOT(1'b0)) dut0 (
      .clk(clk), .reset(reset), .update_pc(update_pc0),
      .redirect_kind(redirect_kind), .branch_imm(branch_imm),
      .jump_index(jump_index), .jump_reg(jump_reg),
      .pc(pc0), .pc_link(pc_link0), .in_delay_slot(in_delay_slot0),
      .halted(halted0), .addr_error(addr_error0)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %08h expected %08h", tag, actual, expected);
      end
   endtask

   // One update_pc strobe on the selected instance; returns on a negedge.
   task automatic apply_stimulus(input bit which, input logic [1:0] kind, input logic [15:0] imm,
                                 input logic [25:0] idx, input logic [31:0] jr);
      @(negedge clk);
      redirect_kind = kind;
      branch_imm    = imm;
      jump_index    = idx;
      jump_reg      = jr;
      if (which) update_pc0 = 1'b1;
      else       update_pc  = 1'b1;
      @(negedge clk);
      update_pc     = 1'b0;
      update_pc0    = 1'b0;
      redirect_kind = 2'b00;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      logic [31:0] exp_pc;
      idle(2);
      reset = 1'b0;
      check_output("reset_pc", pc, 32'hBFC00000);
      check_output("reset_link", pc_link, 32'hBFC00008);
      check_output("reset_ds", {31'd0, in_delay_slot}, 32'd0);
      check_output("reset_halt", {31'd0, halted}, 32'd0);
      check_output("reset_err", {31'd0, addr_error}, 32'd0);
      check_output("reset_pc0", pc0, 32'hBFC00000);

      // Sequential stepping.
      exp_pc = 32'hBFC00000;
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(1'b0, 2'b00, 16'h0, 26'h0, 32'h0);
         exp_pc = exp_pc + 32'd4;
         check_output("seq_pc", pc, exp_pc);
         check_output("seq_link", pc_link, exp_pc + 32'd8);
      end

      // Backward branch with delay slot and an idle gap in SLOT.
      apply_stimulus(1'b0, 2'b01, 16'hFFFE, 26'h0, 32'h0);
      check_output("br_slot_pc", pc, 32'hBFC00014);
      check_output("br_slot_ds", {31'd0, in_delay_slot}, 32'd1);
      idle(3);
      check_output("br_gap_pc", pc, 32'hBFC00014);
      apply_stimulus(1'b0, 2'b10, 16'h0, 26'h3FFFFFF, 32'h0);
      check_output("br_tgt_pc", pc, 32'hBFC0000C);
      check_output("br_tgt_ds", {31'd0, in_delay_slot}, 32'd0);

      // Absolute jump through the delay slot.
      do_reset();
      apply_stimulus(1'b0, 2'b10, 16'h0, 26'h0000040, 32'h0);
      check_output("j_slot_pc", pc, 32'hBFC00004);
      apply_stimulus(1'b0, 2'b00, 16'h0, 26'h0, 32'h0);
      check_output("j_tgt_pc", pc, 32'hB0000100);

      // Misaligned register jump.
      apply_stimulus(1'b0, 2'b11, 16'h0, 26'h0, 32'h00400002);
      check_output("jr_bad_slot_pc", pc, 32'hB0000104);
      check_output("jr_bad_err_pre", {31'd0, addr_error}, 32'd0);
      apply_stimulus(1'b0, 2'b00, 16'h0, 26'h0, 32'h0);
      check_output("jr_bad_err", {31'd0, addr_error}, 32'd1);
      check_output("jr_bad_halt", {31'd0, halted}, 32'd1);
      check_output("jr_bad_pc", pc, 32'hB0000104);
      apply_stimulus(1'b0, 2'b00, 16'h0, 26'h0, 32'h0);
      check_output("jr_bad_hold", pc, 32'hB0000104);

      // Jump to halt address.
      do_reset();
      check_output("rst2_err", {31'd0, addr_error}, 32'd0);
      apply_stimulus(1'b0, 2'b11, 16'h0, 26'h0, 32'h00000000);
      check_output("halt_slot_pc", pc, 32'hBFC00004);
      apply_stimulus(1'b0, 2'b00, 16'h0, 26'h0, 32'h0);
      check_output("halt_pc", pc, 32'h00000000);
      check_output("halt_flag", {31'd0, halted}, 32'd1);
      check_output("halt_err", {31'd0, addr_error}, 32'd0);
      check_output("halt_link", pc_link, 32'h00000008);
      apply_stimulus(1'b0, 2'b01, 16'h0010, 26'h0, 32'h0);
      check_output("halt_hold1", pc, 32'h00000000);
      apply_stimulus(1'b0, 2'b11, 16'h0, 26'h0, 32'h00001000);
      check_output("halt_hold2", pc, 32'h00000000);

      // Reset while a redirect is pending discards it.
      do_reset();
      apply_stimulus(1'b0, 2'b10, 16'h0, 26'h0000040, 32'h0);
      check_output("pend_ds", {31'd0, in_delay_slot}, 32'd1);
      idle(5);
      do_reset();
      check_output("pend_rst_pc", pc, 32'hBFC00000);
      check_output("pend_rst_ds", {31'd0, in_delay_slot}, 32'd0);
      apply_stimulus(1'b0, 2'b00, 16'h0, 26'h0, 32'h0);
      check_output("pend_no_stale", pc, 32'hBFC00004);

      // Reset and update_pc together: reset wins.
      @(negedge clk);
      reset = 1'b1;
      update_pc = 1'b1;
      redirect_kind = 2'b00;
      @(negedge clk);
      reset = 1'b0;
      update_pc = 1'b0;
      check_output("rst_vs_upd", pc, 32'hBFC00000);

      // Immediate-redirect variant.
      do_reset();
      apply_stimulus(1'b1, 2'b10, 16'h0, 26'h0000040, 32'h0);
      check_output("ds0_j_pc", pc0, 32'hB0000100);
      check_output("ds0_j_ds", {31'd0, in_delay_slot0}, 32'd0);
      apply_stimulus(1'b1, 2'b01, 16'h0004, 26'h0, 32'h0);
      check_output("ds0_br_pc", pc0, 32'hB0000114);
      apply_stimulus(1'b1, 2'b11, 16'h0, 26'h0, 32'hFFFFFFFC);
      check_output("ds0_jr_pc", pc0, 32'hFFFFFFFC);
      check_output("ds0_link_wrap", pc_link0, 32'h00000004);
      apply_stimulus(1'b1, 2'b00, 16'h0, 26'h0, 32'h0);
      check_output("ds0_pc_wrap", pc0, 32'h00000000);
      check_output("ds0_wrap_halt", {31'd0, halted0}, 32'd0);
      apply_stimulus(1'b1, 2'b11, 16'h0, 26'h0, 32'h00000003);
      check_output("ds0_bad_err", {31'd0, addr_error0}, 32'd1);
      check_output("ds0_bad_halt", {31'd0, halted0}, 32'd1);
      check_output("ds0_bad_pc", pc0, 32'h00000000);
      check_output("ds1_untouched", pc, 32'hBFC00000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_cpu_pc_seq.md
# mips_cpu_pc_seq

Parametrised program-counter sequencer for the multicycle MIPS core. It generalises the fixed PC register to handle relative branches, absolute J-format jumps and register jumps. A `DELAY_SLOT` parameter selects either the MIPS architectural branch delay slot or immediate redirect. It also owns halt detection (jump to `HALT_ADDR`) and misaligned-target faulting, and sits between the control FSM (which strobes `update_pc`) and instruction fetch (which consumes `pc`).

## Interface
- `RESET_VECTOR`, 32'hBFC00000, value loaded into `pc` on reset
- `HALT_ADDR`, 32'h00000000, reaching this target stops the core
- `DELAY_SLOT`, 1, 1 = MIPS delay slot (redirect after next instruction); 0 = redirect immediately

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high
- `update_pc`  in  1  advance strobe; PC changes only on edges where this is high
- `redirect_kind`  in  2  sampled with `update_pc`: 00 none, 01 branch-relative, 10 jump-absolute, 11 jump-register
- `branch_imm`  in  16  signed word offset for kind 01
- `jump_index`  in  26  instr_index for kind 10
- `jump_reg`  in  32  byte target address for kind 11
- `pc`  out  32  registered current instruction address
- `pc_link`  out  32  combinational `pc + 8` (JAL/JALR link value)
- `in_delay_slot`  out  1  registered; high while `pc` addresses a delay-slot instruction
- `halted`  out  1  registered, sticky until reset
- `addr_error`  out  1  registered, sticky until reset; misaligned redirect target

## Operation
- States: RUN, SLOT (redirect pending), HALTED.
- Target computation, done on the redirect edge using the current `pc`:
  - 01: `pc + 4 + (sext(branch_imm) << 2)`, modulo 2^32.
  - 10: `{(pc+4)[31:28], jump_index, 2'b00}`.
  - 11: `jump_reg`.
- Latch on the redirect edge: the target into `target_q`, and `bad_q = (target[1:0] != 0)`.
- RUN, `update_pc=1`, kind 00: `pc <= pc + 4`.
- RUN, `update_pc=1`, kind != 00:
  - With `DELAY_SLOT=1`: latch the target, `pc <= pc + 4`, `in_delay_slot <= 1`, go to SLOT.
  - With `DELAY_SLOT=0`: perform the commit action below directly; SLOT is never entered.
- SLOT, `update_pc=1`: commit `target_q`, `in_delay_slot <= 0`. `redirect_kind` is ignored (branch in delay slot is architecturally undefined and is dropped).
- Commit action:
  - If `bad_q`: `addr_error <= 1`, `halted <= 1`, `pc` unchanged, go to HALTED.
  - Else if target == `HALT_ADDR`: `pc <= HALT_ADDR`, `halted <= 1`, go to HALTED.
  - Else: `pc <= target`, go to RUN.
- Misalignment applies to all kinds, although only kind 11 can produce it in practice.
- HALTED: all inputs except `reset` ignored; `pc` holds.
- `update_pc=0`: no state, output or latch changes in any state.

## Timing
- Reset values: `pc = RESET_VECTOR`, `in_delay_slot = 0`, `halted = 0`, `addr_error = 0`, state RUN, `target_q = 0`, `bad_q = 0`.
- Reset has priority over everything, including mid-SLOT: the pending redirect is discarded.
- `pc`, `in_delay_slot`, `halted` and `addr_error` update on the same edge that samples `update_pc`; the new values are visible the following cycle.
- Redirect latency with `DELAY_SLOT=1`: target appears in `pc` after the second `update_pc` edge. With `DELAY_SLOT=0`: after the first.
- `update_pc` gaps of any length in SLOT preserve the pending target.
- `pc_link` follows `pc` combinationally with no extra latency; it wraps modulo 2^32.
- `reset` and `update_pc` high together: reset wins.

## Test plan
- Reset, then 3 `update_pc` pulses with kind 00 -> `pc` steps BFC00000, BFC00004, BFC00008, BFC0000C; `pc_link` is always `pc + 8`.
- `DELAY_SLOT=1`, `pc=BFC00010`, kind 01, `branch_imm=16'hFFFE` -> next `pc = BFC00014` with `in_delay_slot=1`; next `update_pc` -> `pc = BFC0000C`, `in_delay_slot=0`.
- `pc=BFC00000`, kind 10, `jump_index=26'h0000040` -> after delay slot, `pc = B0000100`. Repeat with `DELAY_SLOT=0` -> `pc = B0000100` after one edge.
- Kind 11, `jump_reg=0` -> after delay slot, `pc = 0` and `halted = 1`; further `update_pc` with any kind leaves `pc = 0`.
- Kind 11, `jump_reg=32'h00400002` -> after delay slot, `addr_error = 1`, `halted = 1`, `pc` stays at the delay-slot address.
- Redirect pending in SLOT, idle 5 cycles, assert `reset` -> `pc = BFC00000`, `in_delay_slot = 0`; next `update_pc` with kind 00 -> `pc = BFC00004` (no stale redirect).
